// File: rtl/edge_pkg.sv
// Shared types and constants for the Sobel edge job sequencer.
// The status encodings are also read back by the AHB slave status register,
// so the state enum is built directly from them.
package edge_pkg;

   localparam int WIN_SIZE = 9;

   localparam logic [2:0] STAT_IDLE    = 3'b000;
   localparam logic [2:0] STAT_CHECK   = 3'b001;
   localparam logic [2:0] STAT_FETCH   = 3'b010;
   localparam logic [2:0] STAT_COMPUTE = 3'b011;
   localparam logic [2:0] STAT_WRITE   = 3'b100;
   localparam logic [2:0] STAT_NEXT    = 3'b101;
   localparam logic [2:0] STAT_DONE    = 3'b110;
   localparam logic [2:0] STAT_ERROR   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE    = STAT_IDLE,
      ST_CHECK   = STAT_CHECK,
      ST_FETCH   = STAT_FETCH,
      ST_COMPUTE = STAT_COMPUTE,
      ST_WRITE   = STAT_WRITE,
      ST_NEXT    = STAT_NEXT,
      ST_DONE    = STAT_DONE,
      ST_ERROR   = STAT_ERROR
   } edge_state_t;

endpackage

// File: rtl/edge_job_sequencer_addr_gen.sv
// Address generator for the edge job sequencer.
// Holds the pixel row/column counters, the window tap counter and the
// source/destination row base accumulators, and forms the memory address.
// Ports:
//   HCLK, HRESETn        clock, synchronous active-low reset
//   init                 load counters for a new job (r=1, c=1, k=0)
//   tap_adv              advance to the next window tap
//   col_adv              advance to the next interior pixel, k back to 0
//   sel_rd / sel_wr      select window read or result write address
//   width, height        image size
//   src_base, dst_base   image base addresses
//   mem_addr             byte address (0 when neither select is active)
//   tap                  current window tap 0..8
//   last_tap/col/row     terminal flags for k, c and r
module edge_addr_gen
   import edge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              init,
   input  logic              tap_adv,
   input  logic              col_adv,
   input  logic              sel_rd,
   input  logic              sel_wr,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        tap,
   output logic              last_tap,
   output logic              last_col,
   output logic              last_row
);

   logic [DIM_W-1:0]  row_q;
   logic [DIM_W-1:0]  col_q;
   logic [3:0]        tap_q;
   logic [1:0]        tap_dx_q;   // k % 3
   logic [ADDR_W-1:0] tap_off_q;  // (k / 3) * width, built by repeated adds
   logic [ADDR_W-1:0] src_row_q;
   logic [ADDR_W-1:0] dst_row_q;
   logic [ADDR_W-1:0] width_a;
   logic [ADDR_W-1:0] col_a;

   assign width_a  = ADDR_W'(width);
   assign col_a    = ADDR_W'(col_q);
   assign tap      = tap_q;
   assign last_tap = (tap_q == 4'(WIN_SIZE - 1));
   assign last_col = (col_q >= width - DIM_W'(2));
   assign last_row = (row_q >= height - DIM_W'(2));

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         row_q     <= '0;
         col_q     <= '0;
         tap_q     <= '0;
         tap_dx_q  <= '0;
         tap_off_q <= '0;
         src_row_q <= '0;
         dst_row_q <= '0;
      end else if (init) begin
         row_q     <= DIM_W'(1);
         col_q     <= DIM_W'(1);
         tap_q     <= '0;
         tap_dx_q  <= '0;
         tap_off_q <= '0;
         src_row_q <= src_base;
         dst_row_q <= dst_base + width_a;
      end else if (tap_adv) begin
         tap_q <= tap_q + 4'd1;
         if (tap_dx_q == 2'd2) begin
            tap_dx_q  <= '0;
            tap_off_q <= tap_off_q + width_a;
         end else begin
            tap_dx_q <= tap_dx_q + 2'd1;
         end
      end else if (col_adv) begin
         tap_q     <= '0;
         tap_dx_q  <= '0;
         tap_off_q <= '0;
         if (last_col) begin
            col_q     <= DIM_W'(1);
            row_q     <= row_q + DIM_W'(1);
            src_row_q <= src_row_q + width_a;
            dst_row_q <= dst_row_q + width_a;
         end else begin
            col_q <= col_q + DIM_W'(1);
         end
      end
   end

   // Window read: src_row + (k/3)*width + (c-1) + (k%3); c is always >= 1 here.
   always_comb begin
      mem_addr = '0;
      if (sel_rd) begin
         mem_addr = src_row_q + tap_off_q + col_a - ADDR_W'(1) + ADDR_W'(tap_dx_q);
      end else if (sel_wr) begin
         mem_addr = dst_row_q + col_a;
      end
   end

endmodule

// File: rtl/edge_job_sequencer.sv
// Sobel edge job sequencer: walks every interior pixel of an image, fetching
// its 3x3 window into the window buffer, kicking the Sobel core and writing
// the result byte to the destination image.
// Ports:
//   HCLK, HRESETn                 clock, synchronous active-low reset
//   cfg_size_load/src/dst, cfg_data  configuration loads (IDLE only)
//   start                         begin a job
//   mem_req/write/addr, mem_ready single-port memory request interface
//   win_load, win_idx             window buffer capture strobe and slot
//   compute_start, compute_done   Sobel core handshake
//   busy, done, err, status       job status
//
// state   | meaning
// IDLE    | waiting for start, config loads accepted
// CHECK   | validate size, initialise counters
// FETCH   | read window tap k, hold until mem_ready
// COMPUTE | pulse compute_start, wait for compute_done
// WRITE   | write result byte, hold until mem_ready
// NEXT    | step to next interior pixel or finish
// DONE    | one-cycle done pulse
// ERROR   | bad size, err set
module edge_job_sequencer
   import edge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cfg_size_load,
   input  logic              cfg_src_load,
   input  logic              cfg_dst_load,
   input  logic [31:0]       cfg_data,
   input  logic              start,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   output logic              win_load,
   output logic [3:0]        win_idx,
   output logic              compute_start,
   input  logic              compute_done,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        status
);

   edge_state_t       state_q;
   edge_state_t       state_d;
   logic [DIM_W-1:0]  width_q;
   logic [DIM_W-1:0]  height_q;
   logic [ADDR_W-1:0] src_base_q;
   logic [ADDR_W-1:0] dst_base_q;
   logic              err_q;
   logic              cmp_seen_q;   // already one cycle into COMPUTE
   logic              size_bad;
   logic [3:0]        tap;
   logic              last_tap;
   logic              last_col;
   logic              last_row;
   logic              in_idle;
   logic              in_fetch;
   logic              in_write;

   assign in_idle  = (state_q == ST_IDLE);
   assign in_fetch = (state_q == ST_FETCH);
   assign in_write = (state_q == ST_WRITE);
   assign size_bad = (width_q < DIM_W'(3)) || (height_q < DIM_W'(3));

   edge_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W)
   ) u_addr_gen (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .init     (state_q == ST_CHECK),
      .tap_adv  (in_fetch && mem_ready && !last_tap),
      .col_adv  (state_q == ST_NEXT),
      .sel_rd   (in_fetch),
      .sel_wr   (in_write),
      .width    (width_q),
      .height   (height_q),
      .src_base (src_base_q),
      .dst_base (dst_base_q),
      .mem_addr (mem_addr),
      .tap      (tap),
      .last_tap (last_tap),
      .last_col (last_col),
      .last_row (last_row)
   );

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_CHECK;
         ST_CHECK:   state_d = size_bad ? ST_ERROR : ST_FETCH;
         ST_FETCH:   if (mem_ready && last_tap) state_d = ST_COMPUTE;
         ST_COMPUTE: if (compute_done) state_d = ST_WRITE;
         ST_WRITE:   if (mem_ready) state_d = ST_NEXT;
         ST_NEXT:    state_d = (last_col && last_row) ? ST_DONE : ST_FETCH;
         ST_DONE:    state_d = ST_IDLE;
         ST_ERROR:   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      win_load      = 1'b0;
      win_idx       = '0;
      compute_start = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state_q)
         ST_CHECK: busy = 1'b1;
         ST_FETCH: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            win_load = mem_ready;
            win_idx  = tap;
         end
         ST_COMPUTE: begin
            busy          = 1'b1;
            compute_start = !cmp_seen_q;
         end
         ST_WRITE: begin
            busy      = 1'b1;
            mem_req   = 1'b1;
            mem_write = 1'b1;
         end
         ST_NEXT: busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign status = state_q;
   assign err    = err_q;

   // Config, sticky error and compute-start tracking.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         width_q    <= '0;
         height_q   <= '0;
         src_base_q <= '0;
         dst_base_q <= '0;
         err_q      <= 1'b0;
         cmp_seen_q <= 1'b0;
      end else begin
         cmp_seen_q <= (state_q == ST_COMPUTE);
         if (in_idle) begin
            if (cfg_size_load) begin
               width_q  <= cfg_data[DIM_W-1:0];
               height_q <= cfg_data[2*DIM_W-1:DIM_W];
            end
            if (cfg_src_load) src_base_q <= cfg_data[ADDR_W-1:0];
            if (cfg_dst_load) dst_base_q <= cfg_data[ADDR_W-1:0];
            if (start) err_q <= 1'b0;
         end
         // Set on the CHECK->ERROR edge so err is already high in ERROR.
         if (state_q == ST_CHECK && size_bad) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_edge_job_sequencer.sv
module tb_edge_job_sequencer;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        cfg_size_load = 1'b0;
   logic        cfg_src_load = 1'b0;
   logic        cfg_dst_load = 1'b0;
   logic [31:0] cfg_data = '0;
   logic        start = 1'b0;
   logic        mem_req;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        win_load;
   logic [3:0]  win_idx;
   logic        compute_start;
   logic        compute_done;
   logic        busy;
   logic        done;
   logic        err;
   logic [2:0]  status;

   edge_job_sequencer #(.ADDR_W(32), .DIM_W(16)) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .cfg_size_load (cfg_size_load),
      .cfg_src_load  (cfg_src_load),
      .cfg_dst_load  (cfg_dst_load),
      .cfg_data      (cfg_data),
      .start         (start),
      .mem_req       (mem_req),
      .mem_write     (mem_write),
      .mem_addr      (mem_addr),
      .mem_ready     (mem_ready),
      .win_load      (win_load),
      .win_idx       (win_idx),
      .compute_start (compute_start),
      .compute_done  (compute_done),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .status        (status)
   );

   always #5 HCLK = ~HCLK;

   int n_cmp = 0;
   int n_bad = 0;

   // memory / core models
   bit stall_en = 1'b0;
   bit cdly_en  = 1'b0;
   int wait_cnt = 0;
   int cc       = 0;
   int cyc      = 0;

   assign mem_ready    = !(stall_en && mem_req && (mem_write || win_idx == 4'd4) && wait_cnt < 3);
   assign compute_done = !cdly_en || (cc >= 2);

   always @(posedge HCLK) begin
      cyc      <= cyc + 1;
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
      cc       <= (status == 3'd3) ? cc + 1 : 0;
   end

   // monitor, sampled mid-cycle
   logic [31:0] rd_q[$];
   logic [31:0] wr_q[$];
   logic [3:0]  wi_q[$];
   int n_cstart = 0, n_done = 0, n_req = 0;
   int start_cyc = 0, first_req_cyc = 0, done_cyc = 0;
   int stall_cycles = 0, hold_viol = 0;
   bit armed = 1'b0, prev_stall = 1'b0, prev_wr = 1'b0;
   logic [31:0] prev_addr = '0;

   always @(negedge HCLK) begin
      if (HRESETn) begin
         if (prev_stall) begin
            stall_cycles++;
            if (!mem_req || mem_addr !== prev_addr || mem_write !== prev_wr) hold_viol++;
         end
         if (mem_req && !mem_ready && win_load) hold_viol++;
         prev_stall = mem_req && !mem_ready;
         prev_addr  = mem_addr;
         prev_wr    = mem_write;
         if (mem_req && mem_ready && !mem_write) rd_q.push_back(mem_addr);
         if (mem_req && mem_ready && mem_write) wr_q.push_back(mem_addr);
         if (win_load) wi_q.push_back(win_idx);
         if (compute_start) n_cstart++;
         if (done) begin n_done++; done_cyc = cyc; end
         if (mem_req) n_req++;
         if (start && status == 3'd0) begin
            start_cyc = cyc;
            armed = 1'b1;
         end else if (armed && mem_req) begin
            first_req_cyc = cyc;
            armed = 1'b0;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic cfg(input logic s, input logic sr, input logic d, input logic [31:0] data);
      cfg_size_load = s;
      cfg_src_load  = sr;
      cfg_dst_load  = d;
      cfg_data      = data;
      tick();
      cfg_size_load = 1'b0;
      cfg_src_load  = 1'b0;
      cfg_dst_load  = 1'b0;
   endtask

   task automatic setup(input int w, input int h, input logic [31:0] src, input logic [31:0] dst);
      cfg(1'b1, 1'b0, 1'b0, {16'(h), 16'(w)});
      cfg(1'b0, 1'b1, 1'b0, src);
      cfg(1'b0, 1'b0, 1'b1, dst);
   endtask

   int rd0, wr0, wi0, cs0;

   task automatic run_job(input string tag, input bit intrude);
      int d0;
      d0  = n_done;
      rd0 = rd_q.size();
      wr0 = wr_q.size();
      wi0 = wi_q.size();
      cs0 = n_cstart;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (intrude && i == 5) begin
            start = 1'b1; cfg_size_load = 1'b1; cfg_src_load = 1'b1; cfg_dst_load = 1'b1;
            cfg_data = 32'h0008_5000;
         end else if (intrude && i == 6) begin
            start = 1'b0; cfg_size_load = 1'b0; cfg_src_load = 1'b0; cfg_dst_load = 1'b0;
         end
         tick();
         if (n_done != d0) break;
      end
      chk_val({tag, " done_count"}, 32'(n_done - d0), 32'd1);
      chk_val({tag, " busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_job(input string tag, input int w, input int h,
                            input logic [31:0] src, input logic [31:0] dst);
      int n;
      int px;
      logic [31:0] e;
      px = (w - 2) * (h - 2);
      chk_val({tag, " n_reads"}, 32'(rd_q.size() - rd0), 32'(px * 9));
      chk_val({tag, " n_writes"}, 32'(wr_q.size() - wr0), 32'(px));
      chk_val({tag, " n_win_load"}, 32'(wi_q.size() - wi0), 32'(px * 9));
      chk_val({tag, " n_compute_start"}, 32'(n_cstart - cs0), 32'(px));
      n = 0;
      for (int r = 1; r <= h - 2; r++) begin
         for (int c = 1; c <= w - 2; c++) begin
            for (int k = 0; k < 9; k++) begin
               e = src + 32'((r - 1 + k / 3) * w + (c - 1) + (k % 3));
               if (rd0 + n < rd_q.size()) chk_val({tag, " rd_addr"}, rd_q[rd0 + n], e);
               if (wi0 + n < wi_q.size()) chk_val({tag, " win_idx"}, 32'(wi_q[wi0 + n]), 32'(k));
               n++;
            end
            e = dst + 32'(r * w + c);
            if (wr0 + n / 9 - 1 < wr_q.size()) chk_val({tag, " wr_addr"}, wr_q[wr0 + n / 9 - 1], e);
         end
      end
   endtask

   initial begin
      // reset
      repeat (3) tick();
      chk_val("rst mem_req/busy/done/err", {28'd0, mem_req, busy, done, err}, 32'd0);
      chk_val("rst status", 32'(status), 32'd0);
      chk_val("rst mem_addr", mem_addr, 32'd0);
      chk_val("rst win/cstart", {30'd0, win_load, compute_start}, 32'd0);
      HRESETn = 1'b1;
      tick();

      // 3x3 basic job
      setup(3, 3, 32'h1000, 32'h2000);
      run_job("j3x3", 1'b0);
      check_job("j3x3", 3, 3, 32'h1000, 32'h2000);
      chk_val("j3x3 start_to_req", 32'(first_req_cyc - start_cyc), 32'd2);
      chk_val("j3x3 start_to_done", 32'(done_cyc - start_cyc), 32'd14);

      // 4x4 job
      setup(4, 4, 32'h1000, 32'h2000);
      run_job("j4x4", 1'b0);
      check_job("j4x4", 4, 4, 32'h1000, 32'h2000);
      if (rd0 + 9 < rd_q.size()) chk_val("j4x4 px12 first rd", rd_q[rd0 + 9], 32'h1001);
      else chk_val("j4x4 px12 present", 32'(rd_q.size()), 32'(rd0 + 10));

      // bad size 2x5
      begin
         int q0;
         setup(2, 5, 32'h1000, 32'h2000);
         q0 = n_req;
         start = 1'b1; tick(); start = 1'b0;
         chk_val("bad status check", 32'(status), 32'd1);
         tick();
         chk_val("bad status error", 32'(status), 32'd7);
         chk_val("bad err/busy", {30'd0, err, busy}, 32'd2);
         tick();
         chk_val("bad back idle", {28'd0, status, err}, {28'd0, 3'd0, 1'b1});
         chk_val("bad no mem_req", 32'(n_req - q0), 32'd0);
         setup(3, 3, 32'h1000, 32'h2000);
         chk_val("bad err sticky idle", {31'd0, err}, 32'd1);
         run_job("errclr", 1'b0);
         chk_val("errclr err", {31'd0, err}, 32'd0);
         check_job("errclr", 3, 3, 32'h1000, 32'h2000);
      end

      // wait states on read k=4 and on write, delayed compute_done
      begin
         int s0, h0;
         s0 = stall_cycles; h0 = hold_viol;
         stall_en = 1'b1; cdly_en = 1'b1;
         run_job("stall", 1'b0);
         stall_en = 1'b0; cdly_en = 1'b0;
         check_job("stall", 3, 3, 32'h1000, 32'h2000);
         chk_val("stall cycles", 32'(stall_cycles - s0), 32'd6);
         chk_val("stall hold_viol", 32'(hold_viol - h0), 32'd0);
      end

      // reset during FETCH k=5
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (status == 3'd2 && win_idx == 4'd5) break;
         tick();
      end
      chk_val("rstmid reached k5", {25'd0, status, win_idx}, {25'd0, 3'd2, 4'd5});
      HRESETn = 1'b0;
      tick();
      chk_val("rstmid req/busy", {30'd0, mem_req, busy}, 32'd0);
      chk_val("rstmid status", 32'(status), 32'd0);
      HRESETn = 1'b1;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      tick();
      chk_val("rstmid cfg cleared -> err", {29'd0, status, err}, {28'd0, 3'd7, 1'b1});
      tick();
      setup(3, 3, 32'h1000, 32'h2000);
      run_job("rerun", 1'b0);
      check_job("rerun", 3, 3, 32'h1000, 32'h2000);

      // start and config loads while busy are ignored
      setup(4, 4, 32'h1000, 32'h2000);
      run_job("intrude", 1'b1);
      check_job("intrude", 4, 4, 32'h1000, 32'h2000);
      run_job("after_intrude", 1'b0);
      check_job("after_intrude", 4, 4, 32'h1000, 32'h2000);

      // simultaneous loads share cfg_data
      cfg(1'b1, 1'b1, 1'b1, 32'h0003_0003);
      run_job("simul", 1'b0);
      check_job("simul", 3, 3, 32'h0003_0003, 32'h0003_0003);

      // address wrap
      setup(3, 3, 32'hFFFF_FFFC, 32'hFFFF_FFFE);
      run_job("wrap", 1'b0);
      check_job("wrap", 3, 3, 32'hFFFF_FFFC, 32'hFFFF_FFFE);
      if (wr0 < wr_q.size()) chk_val("wrap wr explicit", wr_q[wr0], 32'h0000_0002);
      else chk_val("wrap wr present", 32'(wr_q.size()), 32'(wr0 + 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
